// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one multi-cycle, stall/done-handshaked data memory between the fetch
// stage (instruction reads) and the memory stage (data reads/writes). Requests
// are serialized with fixed data-over-fetch priority, and at most one memory
// transaction is outstanding at a time. A watchdog flags a hung transaction
// through the sticky err output. Protocol violations also set err.
//
// Parameters
//   TIMEOUT   cycles a transaction may wait for m_done before err (1..255)
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   if_req, if_addr              fetch read request (held until if_done)
//   if_rdata, if_done, if_stall  fetch read data, completion pulse, hold
//   d_rd, d_wr, d_addr, d_wdata  memory-stage request (held until d_done)
//   d_rdata, d_done, d_stall     data read result, completion pulse, hold
//   m_addr, m_wdata, m_rd, m_wr  issue to the backing memory (1-cycle strobes)
//   m_stall, m_done, m_rdata     backing memory handshake and read data
//   err                          sticky error flag
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  output logic        m_rd,
  output logic        m_wr,
  input  logic        m_stall,
  input  logic        m_done,
  input  logic [15:0] m_rdata,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_F = 2'd2
  } state_t;

  localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

  state_t      state;
  logic [7:0]  wd_cnt;
  logic        op_wr;       // outstanding data transaction is a write
  logic [15:0] if_rdata_q;
  logic [15:0] d_rdata_q;
  logic        err_q;

  logic       d_req;
  logic       issue_d;
  logic       issue_f;
  logic       done_d;
  logic       done_f;
  logic       proto_err;
  logic       wd_hit;
  logic [8:0] wd_next;

  // Arbitration, completion decode, watchdog threshold and protocol checks.
  // Issue and completion are suppressed during the reset cycle so that an
  // abandoned transaction produces no strobe and no done pulse.
  always_comb begin
    d_req   = d_rd | d_wr;
    issue_d = (state == IDLE) & ~m_stall & d_req & ~rst;
    issue_f = (state == IDLE) & ~m_stall & ~d_req & if_req & ~rst;
    done_d  = (state == BUSY_D) & m_done & ~rst;
    done_f  = (state == BUSY_F) & m_done & ~rst;
    wd_next = {1'b0, wd_cnt} + 9'd1;
    // A completion on the threshold cycle wins over the timeout.
    wd_hit  = (state != IDLE) & ~m_done & (wd_next >= TIMEOUT_W);
    // X/Z detection only matters in simulation; it folds to 0 in hardware.
    proto_err = (d_rd & d_wr)
              | (m_done & (state == IDLE))
              | $isunknown({if_req, d_rd, d_wr, m_stall, m_done})
              | (d_req & $isunknown(^d_addr))
              | (if_req & $isunknown(^if_addr));
  end

  // Arbiter state machine, watchdog counter, read-data holding registers and
  // sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wd_cnt     <= 8'd0;
      op_wr      <= 1'b0;
      if_rdata_q <= 16'd0;
      d_rdata_q  <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_q | proto_err | wd_hit;
      case (state)
        IDLE: begin
          if (issue_d) begin
            state  <= BUSY_D;
            op_wr  <= d_wr;
            wd_cnt <= 8'd0;
          end else if (issue_f) begin
            state  <= BUSY_F;
            op_wr  <= 1'b0;
            wd_cnt <= 8'd0;
          end else begin
            state <= IDLE;
          end
        end
        BUSY_D: begin
          if (m_done) begin
            state <= IDLE;
            // Writes leave the last read result in place.
            if (!op_wr) begin
              d_rdata_q <= m_rdata;
            end else begin
              d_rdata_q <= d_rdata_q;
            end
          end else if (wd_cnt != 8'hFF) begin
            wd_cnt <= wd_cnt + 8'd1;
          end else begin
            wd_cnt <= wd_cnt;
          end
        end
        BUSY_F: begin
          if (m_done) begin
            state      <= IDLE;
            if_rdata_q <= m_rdata;
          end else if (wd_cnt != 8'hFF) begin
            wd_cnt <= wd_cnt + 8'd1;
          end else begin
            wd_cnt <= wd_cnt;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read data is bypassed from the memory on the completion cycle so the
  // pipeline can consume it alongside the done pulse; afterwards it is held.
  assign if_done  = done_f;
  assign d_done   = done_d;
  assign if_rdata = done_f ? m_rdata : if_rdata_q;
  assign d_rdata  = (done_d & ~op_wr) ? m_rdata : d_rdata_q;
  assign if_stall = if_req & ~done_f;
  assign d_stall  = d_req & ~done_d;

  // When idle or busy the address/data buses follow the data port; only a
  // fetch issue steers the address to the fetch port.
  assign m_rd    = issue_d ? d_rd : issue_f;
  assign m_wr    = issue_d & d_wr;
  assign m_addr  = issue_f ? if_addr : d_addr;
  assign m_wdata = d_wdata;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        d_stall;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_rd;
  logic        m_wr;
  logic        m_stall;
  logic        m_done;
  logic [15:0] m_rdata;
  logic        err;

  mem_arbiter #(.TIMEOUT(31)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr),
    .m_stall(m_stall), .m_done(m_done), .m_rdata(m_rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Synthetic memory contents: read data is a fixed function of the address.
  function automatic logic [15:0] mdata(input logic [15:0] a);
    return {a[6:0], a[15:7]} ^ 16'h5A3C;
  endfunction

  typedef struct {
    logic        wr;
    logic [15:0] addr;
  } dreq_t;

  dreq_t       d_q[$];
  logic [15:0] f_q[$];

  // ---------------- scoreboard monitor ----------------
  bit          mon_en = 1'b0;
  int          out_st = 0;    // 0 none, 1 data, 2 fetch outstanding
  int          out_prev;
  bit          done_now;
  logic [15:0] last_d = 16'h0;
  logic [15:0] last_f = 16'h0;
  dreq_t       me;
  logic [15:0] fa;

  always @(negedge clk) begin
    if (!mon_en) begin
      out_st = 0;
      last_d = 16'h0;
      last_f = 16'h0;
    end else begin
      out_prev = out_st;
      done_now = 1'b0;
      chk("if_stall_eq", if_stall, if_req & ~if_done);
      chk("d_stall_eq", d_stall, (d_rd | d_wr) & ~d_done);
      if (m_done && out_prev != 0) begin
        done_now = 1'b1;
        if (out_prev == 1) begin
          chk("d_done_pulse", {d_done, if_done}, 2'b10);
          chk("d_q_nonempty", d_q.size() != 0, 1);
          if (d_q.size() != 0) begin
            me = d_q.pop_front();
            if (!me.wr) last_d = mdata(me.addr);
          end
          chk("d_rdata", d_rdata, last_d);
        end else begin
          chk("if_done_pulse", {d_done, if_done}, 2'b01);
          chk("f_q_nonempty", f_q.size() != 0, 1);
          if (f_q.size() != 0) begin
            fa = f_q.pop_front();
            last_f = mdata(fa);
          end
          chk("if_rdata", if_rdata, last_f);
        end
        out_st = 0;
      end else begin
        chk("no_done", {d_done, if_done}, 2'b00);
        chk("d_rdata_hold", d_rdata, last_d);
        chk("if_rdata_hold", if_rdata, last_f);
      end
      if (m_rd | m_wr) begin
        chk("issue_when_idle", {done_now, out_prev[1:0], m_stall}, 4'h0);
        if (d_rd | d_wr) begin
          chk("d_issue", {m_rd, m_wr, m_addr}, {d_rd, d_wr, d_addr});
          if (d_wr) chk("d_issue_wdata", m_wdata, d_wdata);
          out_st = 1;
        end else begin
          chk("f_issue", {m_rd, m_wr, if_req, m_addr}, {3'b101, if_addr});
          out_st = 2;
        end
      end else if (out_prev == 0 && !m_stall && (d_rd | d_wr | if_req)) begin
        chk("issue_missing", m_rd | m_wr, 1);
      end
    end
  end

  // ---------------- random stimulus: requesters and memory ----------------
  bit          d_act = 1'b0;
  bit          f_act = 1'b0;
  bit          mbusy = 1'b0;
  int          mwait = 0;
  logic [15:0] maddr = 16'h0;

  task automatic rand_cycle(input bit go);
    logic        c_issue;
    logic [15:0] c_addr;
    logic        c_ddone;
    logic        c_fdone;
    dreq_t       e;
    @(negedge clk);
    c_issue = m_rd | m_wr;
    c_addr  = m_addr;
    c_ddone = d_done;
    c_fdone = if_done;
    @(posedge clk);
    #1;
    // memory model: done 1..4 cycles after issue
    if (m_done) begin
      m_done = 1'b0;
      mbusy  = 1'b0;
    end else if (c_issue) begin
      mbusy = 1'b1;
      mwait = $urandom_range(0, 3);
      maddr = c_addr;
    end else if (mbusy && mwait != 0) begin
      mwait--;
    end
    if (mbusy && !m_done && mwait == 0) begin
      m_done  = 1'b1;
      m_rdata = mdata(maddr);
    end else begin
      m_rdata = 16'($urandom);
    end
    m_stall = ($urandom_range(0, 3) == 0);
    // memory-stage requester
    if (d_act) begin
      if (c_ddone) begin
        d_rd  = 1'b0;
        d_wr  = 1'b0;
        d_act = 1'b0;
      end
    end else if (go && $urandom_range(0, 9) < 4) begin
      e.wr    = 1'($urandom_range(0, 1));
      e.addr  = 16'($urandom);
      d_addr  = e.addr;
      d_wdata = 16'($urandom);
      d_rd    = ~e.wr;
      d_wr    = e.wr;
      d_act   = 1'b1;
      d_q.push_back(e);
    end else begin
      d_addr  = 16'($urandom);
      d_wdata = 16'($urandom);
    end
    // fetch requester
    if (f_act) begin
      if (c_fdone) begin
        if_req = 1'b0;
        f_act  = 1'b0;
      end
    end else if (go && $urandom_range(0, 9) < 5) begin
      if_addr = 16'($urandom);
      if_req  = 1'b1;
      f_act   = 1'b1;
      f_q.push_back(if_addr);
    end else begin
      if_addr = 16'($urandom);
    end
  endtask

  // ---------------- directed helpers ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic do_reset;
    step; rst = 1'b1;
    step; rst = 1'b0;
  endtask

  int rd_cnt;
  int stall_cnt;

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = 16'h0; d_rd = 1'b0; d_wr = 1'b0;
    d_addr = 16'h0; d_wdata = 16'h0; m_stall = 1'b0; m_done = 1'b0; m_rdata = 16'h0;

    // reset state
    step; step; rst = 1'b0;
    smp;
    chk("reset_outputs", {if_done, if_stall, d_done, d_stall, m_rd, m_wr, err}, 7'h0);
    chk("reset_rdata", {if_rdata, d_rdata, m_addr, m_wdata}, 64'h0);

    // fetch read with 3 waiting cycles
    step; if_req = 1'b1; if_addr = 16'h0010;
    smp;
    chk("f_issue_addr", {m_rd, m_wr, m_addr}, {2'b10, 16'h0010});
    rd_cnt = int'(m_rd); stall_cnt = int'(if_stall);
    for (int i = 0; i < 3; i++) begin
      step; smp;
      rd_cnt += int'(m_rd); stall_cnt += int'(if_stall);
      chk("f_wait_no_done", if_done, 1'b0);
    end
    step; m_done = 1'b1; m_rdata = 16'hBEEF;
    smp;
    rd_cnt += int'(m_rd); stall_cnt += int'(if_stall);
    chk("f_done", {if_done, if_rdata}, {1'b1, 16'hBEEF});
    chk("f_stall_cycles", stall_cnt, 4);
    chk("f_rd_pulses", rd_cnt, 1);
    step; m_done = 1'b0; m_rdata = 16'h0; if_req = 1'b0;
    smp;
    chk("f_rdata_held", {if_done, m_rd, if_rdata}, {2'b00, 16'hBEEF});

    // contention: data first, fetch the cycle after d_done
    step; if_req = 1'b1; if_addr = 16'h0020; d_rd = 1'b1; d_addr = 16'h0100;
    smp;
    chk("c_d_first", {m_rd, m_addr, if_stall}, {1'b1, 16'h0100, 1'b1});
    step; m_done = 1'b1; m_rdata = 16'h1234;
    smp;
    chk("c_d_done", {d_done, if_done, m_rd, if_stall, d_rdata}, {4'b1001, 16'h1234});
    step; m_done = 1'b0; d_rd = 1'b0;
    smp;
    chk("c_f_issue", {m_rd, m_addr, if_stall}, {1'b1, 16'h0020, 1'b1});
    step; m_done = 1'b1; m_rdata = 16'h5678;
    smp;
    chk("c_f_done", {if_done, if_rdata, d_rdata}, {1'b1, 16'h5678, 16'h1234});

    // write path with two stalled cycles
    step; m_done = 1'b0; if_req = 1'b0;
    d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'hA5A5; m_stall = 1'b1;
    smp;
    chk("w_stall1", {m_wr, m_rd, d_stall}, 3'b001);
    step; smp;
    chk("w_stall2", {m_wr, m_rd}, 2'b00);
    step; m_stall = 1'b0;
    smp;
    chk("w_issue", {m_wr, m_rd, m_addr, m_wdata}, {2'b10, 16'h0200, 16'hA5A5});
    step; m_done = 1'b1; m_rdata = 16'hDEAD;
    smp;
    chk("w_done", {d_done, d_rdata}, {1'b1, 16'h1234});
    step; m_done = 1'b0; d_wr = 1'b0;
    smp;
    chk("err_clean", err, 1'b0);

    // watchdog: no m_done ever
    step; d_rd = 1'b1; d_addr = 16'h0300;
    smp;
    chk("wd_issue", m_rd, 1'b1);
    repeat (31) begin step; smp; end
    chk("wd_before", err, 1'b0);
    step; smp;
    chk("wd_at", err, 1'b1);
    step; d_rd = 1'b0;
    repeat (3) begin step; smp; end
    chk("wd_sticky", err, 1'b1);
    do_reset; smp;
    chk("wd_cleared", err, 1'b0);

    // protocol errors
    step; d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0400;
    smp;
    step; d_rd = 1'b0; d_wr = 1'b0;
    smp;
    chk("err_rdwr", err, 1'b1);
    do_reset; smp;
    chk("err_rst", err, 1'b0);
    step; m_done = 1'b1;
    smp;
    step; m_done = 1'b0;
    smp;
    chk("err_idle_done", err, 1'b1);
    do_reset;

    // reset while a fetch is outstanding
    step; if_req = 1'b1; if_addr = 16'h0040;
    smp;
    chk("r_issue", m_rd, 1'b1);
    step; smp;
    step; rst = 1'b1; m_done = 1'b1; m_rdata = 16'h1111;
    smp;
    chk("r_in_reset", {if_done, m_rd, m_wr}, 3'b000);
    step; rst = 1'b0; m_done = 1'b0;
    smp;
    chk("r_reissue", {m_rd, m_addr, if_done, err}, {1'b1, 16'h0040, 2'b00});
    step; m_done = 1'b1; m_rdata = 16'h2222;
    smp;
    chk("r_done", {if_done, if_rdata}, {1'b1, 16'h2222});
    step; m_done = 1'b0; if_req = 1'b0;

    // randomized traffic against the scoreboard
    do_reset;
    mon_en = 1'b1;
    for (int i = 0; i < 3000; i++) rand_cycle(1'b1);
    for (int i = 0; i < 200 && (d_act || f_act || mbusy); i++) rand_cycle(1'b0);
    chk("drain", {d_act, f_act, mbusy}, 3'b000);
    step;
    mon_en = 1'b0;
    chk("queues_empty", d_q.size() + f_q.size(), 0);
    chk("rand_err", err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
